// File: rtl/logic_response_checker.sv
// Self-test engine that walks all 32 stimulus vectors through the AND/OR/NOT/FF/MUX1/MUX2 element set
// and compares each element output against a golden model, reporting pass, failure count and first failure.
module logic_response_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             start,
  output logic [1:0]       stim_a,
  output logic [1:0]       stim_b,
  output logic             stim_sel,
  input  logic             out_and,
  input  logic             out_or,
  input  logic             out_not,
  input  logic             out_ff,
  input  logic             out_mux1,
  input  logic [1:0]       out_mux2,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [4:0]       first_fail_vec,
  output logic [5:0]       first_fail_mask
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_APPLY = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int              CNT_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic [1:0]       state;
  logic [4:0]       vec;
  logic [CNT_W-1:0] settle_cnt;
  logic [5:0]       mask;
  logic             a0;
  logic             b0;
  logic             sel;
  logic [1:0]       exp_mux2;

  // Stimulus comes straight from the vector register, so it is registered and zero in reset.
  assign stim_a   = vec[1:0];
  assign stim_b   = vec[3:2];
  assign stim_sel = vec[4];

  assign busy = (state == ST_APPLY) || (state == ST_CHECK);
  assign done = (state == ST_DONE);
  assign pass = done && (err_count == '0);

  // Golden model; !== makes X/Z on any element output count as a mismatch.
  always_comb begin
    a0       = vec[0];
    b0       = vec[2];
    sel      = vec[4];
    exp_mux2 = sel ? vec[3:2] : vec[1:0];
    mask     = '0;
    mask[0]  = (out_and  !== (a0 & b0));
    mask[1]  = (out_or   !== (a0 | b0));
    mask[2]  = (out_not  !== ~a0);
    mask[3]  = (out_ff   !== a0);
    mask[4]  = (out_mux1 !== (sel ? b0 : a0));
    mask[5]  = (out_mux2 !== exp_mux2);
  end

  // start is a level, not a handshake: it is only sampled in IDLE or DONE and ignored while busy.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state           <= ST_IDLE;
      vec             <= '0;
      settle_cnt      <= '0;
      err_count       <= '0;
      first_fail_vec  <= '0;
      first_fail_mask <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state           <= ST_APPLY;
            vec             <= '0;
            settle_cnt      <= '0;
            err_count       <= '0;
            first_fail_vec  <= '0;
            first_fail_mask <= '0;
          end
        end
        ST_APPLY: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            state      <= ST_CHECK;
          end else begin
            settle_cnt <= settle_cnt + CNT_W'(1);
          end
        end
        ST_CHECK: begin
          if (|mask) begin
            if (err_count != '1) err_count <= err_count + ERR_W'(1);
            // err_count still zero means this is the first failing vector of the run.
            if (err_count == '0) begin
              first_fail_vec  <= vec;
              first_fail_mask <= mask;
            end
          end
          if (vec == 5'd31) begin
            state <= ST_DONE;
          end else begin
            vec   <= vec + 5'd1;
            state <= ST_APPLY;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_response_checker.sv
// Bench for logic_response_checker: models the six elements with injectable faults and checks
// run timing and reported results against a vector-walking reference model.
module tb_logic_response_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_L;
  logic start0, start1;

  // checker with default settle (2) driving a faultable element set
  logic [1:0] stim_a0, stim_b0;
  logic       stim_sel0;
  logic       and0, or0, not0, ff0, ff_q0, mux1_0;
  logic [1:0] mux2_0;
  logic       busy0, done0, pass0;
  logic [7:0] err0;
  logic [4:0] fv0;
  logic [5:0] fm0;

  // checker with settle of 1 driving a clean element set
  logic [1:0] stim_a1, stim_b1;
  logic       stim_sel1;
  logic       and1, or1, not1, ff_q1, mux1_1;
  logic [1:0] mux2_1;
  logic       busy1, done1, pass1;
  logic [7:0] err1;
  logic [4:0] fv1;
  logic [5:0] fm1;

  // fault_sel: 0 AND, 1 OR, 2 NOT, 3 FF, 4 MUX1, 5 MUX2 stuck at 'stuck'; 6 none
  int   fault_sel = 6;
  logic stuck     = 1'b0;
  logic swap      = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_q[$];

  always @(posedge clk) ff_q0 <= stim_a0[0];
  always @(posedge clk) ff_q1 <= stim_a1[0];

  always_comb begin
    and0   = (fault_sel == 0) ? stuck : (stim_a0[0] & stim_b0[0]);
    or0    = (fault_sel == 1) ? stuck : (stim_a0[0] | stim_b0[0]);
    not0   = (fault_sel == 2) ? stuck : ~stim_a0[0];
    ff0    = (fault_sel == 3) ? stuck : ff_q0;
    mux1_0 = (fault_sel == 4) ? stuck : (stim_sel0 ? stim_b0[0] : stim_a0[0]);
    if (fault_sel == 5) mux2_0 = {stuck, stuck};
    else if (swap)      mux2_0 = stim_sel0 ? stim_a0 : stim_b0;
    else                mux2_0 = stim_sel0 ? stim_b0 : stim_a0;
  end

  always_comb begin
    and1   = stim_a1[0] & stim_b1[0];
    or1    = stim_a1[0] | stim_b1[0];
    not1   = ~stim_a1[0];
    mux1_1 = stim_sel1 ? stim_b1[0] : stim_a1[0];
    mux2_1 = stim_sel1 ? stim_b1 : stim_a1;
  end

  logic_response_checker #(.SETTLE_CYCLES(2), .ERR_W(8)) dut (
    .clk(clk), .reset_L(reset_L), .start(start0),
    .stim_a(stim_a0), .stim_b(stim_b0), .stim_sel(stim_sel0),
    .out_and(and0), .out_or(or0), .out_not(not0), .out_ff(ff0),
    .out_mux1(mux1_0), .out_mux2(mux2_0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .first_fail_vec(fv0), .first_fail_mask(fm0)
  );

  logic_response_checker #(.SETTLE_CYCLES(1), .ERR_W(8)) dut1 (
    .clk(clk), .reset_L(reset_L), .start(start1),
    .stim_a(stim_a1), .stim_b(stim_b1), .stim_sel(stim_sel1),
    .out_and(and1), .out_or(or1), .out_not(not1), .out_ff(ff_q1),
    .out_mux1(mux1_1), .out_mux2(mux2_1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_fail_vec(fv1), .first_fail_mask(fm1)
  );

  // Reference: walk all 32 vectors, derive what each element would produce under the fault, and
  // collect the failing-vector count and the first failure.
  task automatic model_run(input int fsel, input int stk, input int swp,
                           output int exp_err, output int exp_fv, output int exp_fm);
    int a, b, s, a0, b0, m;
    int r[6];
    int d[6];
    exp_err = 0; exp_fv = 0; exp_fm = 0;
    for (int v = 0; v < 32; v++) begin
      a = v % 4; b = (v / 4) % 4; s = v / 16;
      a0 = a % 2; b0 = b % 2;
      r[0] = a0 * b0;
      r[1] = (a0 + b0 > 0) ? 1 : 0;
      r[2] = 1 - a0;
      r[3] = a0;
      r[4] = (s == 1) ? b0 : a0;
      r[5] = (s == 1) ? b : a;
      for (int k = 0; k < 6; k++) d[k] = r[k];
      if (swp != 0) d[5] = (s == 1) ? a : b;
      if (fsel < 5) d[fsel] = stk;
      if (fsel == 5) d[5] = stk * 3;
      m = 0;
      for (int k = 0; k < 6; k++) if (d[k] != r[k]) m += (1 << k);
      if (m != 0) begin
        if (exp_err == 0) begin exp_fv = v; exp_fm = m; end
        if (exp_err < 255) exp_err++;
      end
    end
  endtask

  task automatic pulse_start(input bit which);
    @(posedge clk); #1;
    if (which) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
  endtask

  // Counts cycles from the start-sampling edge until done, bounded by budget.
  task automatic wait_done(input bit which, input int budget, output int cycles, output int busy_cyc);
    cycles = 0; busy_cyc = 0;
    while (!(which ? done1 : done0) && cycles < budget) begin
      if (which ? busy1 : busy0) busy_cyc++;
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic test_reset;
    reset_L = 1'b1; start0 = 1'b0; start1 = 1'b0;
    #2 reset_L = 1'b0;
    #1;
    if ({busy0, done0, pass0, err0, fv0, fm0, stim_sel0, stim_b0, stim_a0} !== 27'd0) begin
      errors++; $display("FAIL reset_dut: got %h expected 0", {busy0, done0, pass0, err0, fv0, fm0, stim_sel0, stim_b0, stim_a0});
    end
    checks++;
    if ({busy1, done1, pass1, err1, fv1, fm1, stim_sel1, stim_b1, stim_a1} !== 27'd0) begin
      errors++; $display("FAIL reset_dut1: got %h expected 0", {busy1, done1, pass1, err1, fv1, fm1, stim_sel1, stim_b1, stim_a1});
    end
    checks++;
    repeat (2) @(posedge clk);
    #1 reset_L = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_clean_run;
    int cycles, busy_cyc;
    logic [4:0] cur, last, e;
    bit first;
    fault_sel = 6; swap = 1'b0;
    for (int v = 0; v < 32; v++) exp_q.push_back(5'(v));
    pulse_start(1'b0);
    cycles = 0; busy_cyc = 0; first = 1'b1; last = '0;
    while (!done0 && cycles < 200) begin
      if (busy0) begin
        busy_cyc++;
        cur = {stim_sel0, stim_b0, stim_a0};
        if (first || cur != last) begin
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 5'd0;
          if (cur !== e) begin errors++; $display("FAIL stim_seq: got %0d expected %0d", cur, e); end
          checks++;
        end
        first = 1'b0; last = cur;
      end
      @(posedge clk); #1;
      cycles++;
    end
    if (exp_q.size() != 0) begin errors++; $display("FAIL stim_count: got %0d left expected 0", exp_q.size()); end
    checks++;
    exp_q.delete();
    if (cycles != 96) begin errors++; $display("FAIL clean_cycles: got %0d expected 96", cycles); end
    checks++;
    if (busy_cyc != 96) begin errors++; $display("FAIL clean_busy: got %0d expected 96", busy_cyc); end
    checks++;
    if ({done0, pass0, err0, fm0} !== {1'b1, 1'b1, 8'd0, 6'd0}) begin
      errors++; $display("FAIL clean_result: got done=%b pass=%b err=%0d mask=%b expected 1 1 0 0", done0, pass0, err0, fm0);
    end
    checks++;
  endtask

  task automatic test_directed_faults;
    int t_fsel[3] = '{6, 0, 6};
    int t_swp[3]  = '{0, 0, 1};
    int t_err[3]  = '{0, 8, 24};
    int t_fv[3]   = '{0, 5, 1};
    int t_fm[3]   = '{0, 1, 32};
    int cycles, busy_cyc;
    for (int i = 0; i < 3; i++) begin
      fault_sel = t_fsel[i]; stuck = 1'b0; swap = t_swp[i][0];
      pulse_start(1'b0);
      wait_done(1'b0, 200, cycles, busy_cyc);
      if (cycles != 96) begin errors++; $display("FAIL dir%0d_cycles: got %0d expected 96", i, cycles); end
      checks++;
      if (err0 !== 8'(t_err[i])) begin errors++; $display("FAIL dir%0d_err: got %0d expected %0d", i, err0, t_err[i]); end
      checks++;
      if (fv0 !== 5'(t_fv[i])) begin errors++; $display("FAIL dir%0d_vec: got %0d expected %0d", i, fv0, t_fv[i]); end
      checks++;
      if (fm0 !== 6'(t_fm[i])) begin errors++; $display("FAIL dir%0d_mask: got %b expected %b", i, fm0, 6'(t_fm[i])); end
      checks++;
      if (pass0 !== (t_err[i] == 0)) begin errors++; $display("FAIL dir%0d_pass: got %b expected %b", i, pass0, t_err[i] == 0); end
      checks++;
    end
    fault_sel = 6; swap = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    int n, cycles, busy_cyc;
    fault_sel = 0; stuck = 1'b0;
    pulse_start(1'b0);
    n = 0;
    while ({stim_sel0, stim_b0, stim_a0} != 5'd10 && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) begin errors++; $display("FAIL mid_reach10: got timeout expected vector 10"); end
    checks++;
    #2 reset_L = 1'b0;
    #1;
    if ({busy0, done0, pass0, err0, fv0, fm0, stim_sel0, stim_b0, stim_a0} !== 27'd0) begin
      errors++; $display("FAIL mid_reset: got %h expected 0", {busy0, done0, pass0, err0, fv0, fm0, stim_sel0, stim_b0, stim_a0});
    end
    checks++;
    @(posedge clk); #1 reset_L = 1'b1;
    fault_sel = 6;
    repeat (5) @(posedge clk);
    #1;
    if ({busy0, done0, err0} !== 10'd0) begin
      errors++; $display("FAIL mid_idle: got busy=%b done=%b err=%0d expected 0 0 0", busy0, done0, err0);
    end
    checks++;
    pulse_start(1'b0);
    wait_done(1'b0, 200, cycles, busy_cyc);
    if ({cycles == 96, pass0, err0, fm0} !== {1'b1, 1'b1, 8'd0, 6'd0}) begin
      errors++; $display("FAIL mid_rerun: got cycles=%0d pass=%b err=%0d mask=%b expected 96 1 0 0", cycles, pass0, err0, fm0);
    end
    checks++;
  endtask

  task automatic test_start_held;
    int cycles, busy_cyc;
    fault_sel = 0; stuck = 1'b0;
    @(posedge clk); #1 start0 = 1'b1;
    @(posedge clk); #1;
    wait_done(1'b0, 200, cycles, busy_cyc);
    if (cycles != 96) begin errors++; $display("FAIL held_cycles: got %0d expected 96", cycles); end
    checks++;
    if (err0 !== 8'd8 || fv0 !== 5'd5) begin errors++; $display("FAIL held_result: got err=%0d vec=%0d expected 8 5", err0, fv0); end
    checks++;
    @(posedge clk); #1;
    if ({busy0, done0, err0, stim_sel0, stim_b0, stim_a0} !== {1'b1, 1'b0, 8'd0, 5'd0}) begin
      errors++; $display("FAIL held_restart: got busy=%b done=%b err=%0d vec=%0d expected 1 0 0 0", busy0, done0, err0, {stim_sel0, stim_b0, stim_a0});
    end
    checks++;
    start0 = 1'b0;
    wait_done(1'b0, 200, cycles, busy_cyc);
    if (cycles != 96 || err0 !== 8'd8) begin errors++; $display("FAIL held_second: got cycles=%0d err=%0d expected 96 8", cycles, err0); end
    checks++;
    fault_sel = 6;
  endtask

  task automatic test_settle1;
    int cycles, busy_cyc;
    pulse_start(1'b1);
    wait_done(1'b1, 200, cycles, busy_cyc);
    if (cycles != 64) begin errors++; $display("FAIL settle1_cycles: got %0d expected 64", cycles); end
    checks++;
    if ({pass1, err1, fm1} !== {1'b1, 8'd0, 6'd0}) begin
      errors++; $display("FAIL settle1_result: got pass=%b err=%0d mask=%b expected 1 0 0", pass1, err1, fm1);
    end
    checks++;
  endtask

  task automatic test_random;
    int fsel, stk, swp, e_err, e_fv, e_fm, cycles, busy_cyc;
    for (int it = 0; it < 10; it++) begin
      fsel = $urandom_range(0, 6); stk = $urandom_range(0, 1); swp = $urandom_range(0, 1);
      fault_sel = fsel; stuck = stk[0]; swap = swp[0];
      model_run(fsel, stk, swp, e_err, e_fv, e_fm);
      repeat ($urandom_range(0, 4)) @(posedge clk);
      pulse_start(1'b0);
      wait_done(1'b0, 200, cycles, busy_cyc);
      if (cycles != 32 * 3) begin errors++; $display("FAIL rnd%0d_cycles: got %0d expected %0d", it, cycles, 32 * 3); end
      checks++;
      if (err0 !== 8'(e_err) || fv0 !== 5'(e_fv) || fm0 !== 6'(e_fm) || pass0 !== (e_err == 0)) begin
        errors++;
        $display("FAIL rnd%0d_result (fsel=%0d stk=%0d swp=%0d): got err=%0d vec=%0d mask=%b pass=%b expected %0d %0d %b %b",
                 it, fsel, stk, swp, err0, fv0, fm0, pass0, e_err, e_fv, 6'(e_fm), e_err == 0);
      end
      checks++;
    end
    fault_sel = 6; swap = 1'b0;
  endtask

  initial begin
    test_reset;
    test_clean_run;
    test_directed_faults;
    test_reset_mid_run;
    test_start_held;
    test_settle1;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
